// File: rtl/core_pixel_rot_agen_if.sv
// Pixel rotation address generator: config, handshake and status bundle.
// master drives config/control into the generator, slave is the generator.
interface core_pixel_rot_agen_if #(
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 16
);
  logic [DIM_W-1:0]  I_CP_WIDTH;
  logic [DIM_W-1:0]  I_CP_HEIGHT;
  logic [1:0]        I_CP_DEGREES;
  logic              I_CP_DIRECTION;
  logic              I_CP_FLIP;
  logic              I_CP_START;
  logic              I_CP_ABORT;
  logic              I_CP_READY;
  logic [ADDR_W-1:0] O_CP_SRC_ADDR;
  logic [ADDR_W-1:0] O_CP_DST_ADDR;
  logic              O_CP_VALID;
  logic              O_CP_LAST;
  logic              O_CP_BUSY;
  logic              O_CP_DONE;
  logic              O_CP_ERR;

  modport master (
    output I_CP_WIDTH, I_CP_HEIGHT, I_CP_DEGREES,
    output I_CP_DIRECTION, I_CP_FLIP, I_CP_START,
    output I_CP_ABORT, I_CP_READY,
    input  O_CP_SRC_ADDR, O_CP_DST_ADDR, O_CP_VALID,
    input  O_CP_LAST, O_CP_BUSY, O_CP_DONE, O_CP_ERR
  );

  modport slave (
    input  I_CP_WIDTH, I_CP_HEIGHT, I_CP_DEGREES,
    input  I_CP_DIRECTION, I_CP_FLIP, I_CP_START,
    input  I_CP_ABORT, I_CP_READY,
    output O_CP_SRC_ADDR, O_CP_DST_ADDR, O_CP_VALID,
    output O_CP_LAST, O_CP_BUSY, O_CP_DONE, O_CP_ERR
  );
endinterface

// File: rtl/core_pixel_rot_agen.sv
// Rotated (src, dst) pixel address pair generator with valid/ready.
// Optional mirror feature: define CORE_PIXEL_FLIP_EN.
module core_pixel_rot_agen #(
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 16,
  parameter int BPP    = 3
) (
  input  logic                I_CP_HCLK,
  input  logic                I_CP_HRESET_N,
  core_pixel_rot_agen_if.slave cp
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

  localparam logic [ADDR_W-1:0] BSZ = ADDR_W'(BPP);

  state_t            st;
  logic [DIM_W-1:0]  w_q, h_q, r_q, c_q;
  logic [DIM_W-1:0]  wm1, hm1;
  logic [1:0]        a_q;
  logic              flip_q;
  logic [ADDR_W-1:0] src_q, dst_q, row_q;
  logic [ADDR_W-1:0] cs_q, rs_q;
  logic [ADDR_W-1:0] wb, hb, whb;
  logic [ADDR_W-1:0] dst0, cs, rs;
  logic              valid_q, last_q;
  logic              busy_q, done_q, err_q;
  logic              zero_dim, c_end;

  assign wm1      = w_q - DIM_W'(1);
  assign hm1      = h_q - DIM_W'(1);
  assign c_end    = (c_q == wm1);
  assign zero_dim = (cp.I_CP_WIDTH == '0) ||
                    (cp.I_CP_HEIGHT == '0);

  // Products only feed the one-cycle LOAD setup.
  assign wb  = ADDR_W'(w_q) * BSZ;
  assign hb  = ADDR_W'(h_q) * BSZ;
  assign whb = ADDR_W'(w_q) * hb;

  // Row-0 start, column step and row step per effective CW angle.
  always_comb begin
    dst0 = '0;
    cs   = '0;
    rs   = '0;
    unique case (a_q)
      2'd0: begin
        dst0 = flip_q ? wb - BSZ : '0;
        cs   = flip_q ? -BSZ : BSZ;
        rs   = wb;
      end
      2'd1: begin
        dst0 = flip_q ? '0 : hb - BSZ;
        cs   = hb;
        rs   = flip_q ? BSZ : -BSZ;
      end
      2'd2: begin
        dst0 = flip_q ? whb - wb : whb - BSZ;
        cs   = flip_q ? BSZ : -BSZ;
        rs   = -wb;
      end
      2'd3: begin
        dst0 = flip_q ? whb - BSZ : whb - hb;
        cs   = -hb;
        rs   = flip_q ? -BSZ : BSZ;
      end
    endcase
  end

`ifdef CORE_PIXEL_FLIP_EN
  always_ff @(posedge I_CP_HCLK) begin
    if (!I_CP_HRESET_N)
      flip_q <= 1'b0;
    else if (st == IDLE && cp.I_CP_START &&
             !cp.I_CP_ABORT)
      flip_q <= cp.I_CP_FLIP;
  end
`else
  assign flip_q = 1'b0;
`endif

  always_ff @(posedge I_CP_HCLK) begin
    if (!I_CP_HRESET_N) begin
      st      <= IDLE;
      w_q     <= '0;
      h_q     <= '0;
      a_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      row_q   <= '0;
      cs_q    <= '0;
      rs_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (cp.I_CP_ABORT) begin
      st      <= IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (st)
        IDLE: if (cp.I_CP_START) begin
          if (zero_dim) begin
            err_q <= 1'b1;
          end else begin
            w_q    <= cp.I_CP_WIDTH;
            h_q    <= cp.I_CP_HEIGHT;
            a_q    <= cp.I_CP_DIRECTION ?
                      2'd0 - cp.I_CP_DEGREES :
                      cp.I_CP_DEGREES;
            busy_q <= 1'b1;
            st     <= LOAD;
          end
        end
        LOAD: begin
          src_q <= '0;
          dst_q <= dst0;
          row_q <= dst0;
          cs_q  <= cs;
          rs_q  <= rs;
          r_q   <= '0;
          c_q   <= '0;
          st    <= RUN;
        end
        RUN: if (!valid_q) begin
          valid_q <= 1'b1;
          last_q  <= (wm1 == '0) && (hm1 == '0);
        end else if (cp.I_CP_READY) begin
          if (last_q) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b1;
            st      <= FIN;
          end else begin
            src_q <= src_q + BSZ;
            if (c_end) begin
              c_q    <= '0;
              r_q    <= r_q + DIM_W'(1);
              row_q  <= row_q + rs_q;
              dst_q  <= row_q + rs_q;
              last_q <= (wm1 == '0) &&
                        (r_q + DIM_W'(1) == hm1);
            end else begin
              c_q    <= c_q + DIM_W'(1);
              dst_q  <= dst_q + cs_q;
              last_q <= (c_q + DIM_W'(1) == wm1) &&
                        (r_q == hm1);
            end
          end
        end
        FIN: begin
          busy_q <= 1'b0;
          st     <= IDLE;
        end
      endcase
    end
  end

  assign cp.O_CP_SRC_ADDR = src_q;
  assign cp.O_CP_DST_ADDR = dst_q;
  assign cp.O_CP_VALID    = valid_q;
  assign cp.O_CP_LAST     = last_q;
  assign cp.O_CP_BUSY     = busy_q;
  assign cp.O_CP_DONE     = done_q;
  assign cp.O_CP_ERR      = err_q;
endmodule
